foo_intf_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one foo_intf sink among N foo_intf sources, one owner at a time.
- Sits between an array of foo_intf source instances and a single downstream sink.
- Registers the owner's `a` bit onto the sink.
- Enforces a one-cycle dead turnaround between owners and an optional maximum hold time with preemption.

---
 rtl/foo_intf_rr_arbiter.sv | 105 ++++++++++
 tb/tb_foo_intf_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/foo_intf_rr_arbiter.sv
// Round-robin arbiter sharing one foo_intf sink among N sources.
// One owner at a time, a one-cycle dead GAP between owners, and an
// optional hold limit that forces a handover when others are waiting.
module foo_intf_rr_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 8,
  parameter int IDXW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    rel,
  input  logic [N-1:0]    a_src,
  output logic [N-1:0]    grant,
  output logic            grant_vld,
  output logic [IDXW-1:0] grant_idx,
  output logic            a_sink,
  output logic            preempt
);

  // Hold counter must represent 1 even when the hold limit is disabled.
  localparam int            HW   = $clog2(MAX_HOLD + 2);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [HW-1:0]   hcnt;

  logic            win_vld;
  logic [IDXW-1:0] win_idx;
  int              cand;
  logic            owner_rel;
  logic            others;
  logic            force_out;
  logic [IDXW-1:0] nxt_ptr;

  // Circular first-requester search starting at the priority pointer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = IDXW'(cand);
      end
    end
  end

  // Owner exit conditions; an explicit release always beats preemption.
  always_comb begin
    owner_rel = rel[grant_idx] | ~req[grant_idx];
    others    = |(req & ~grant);
    force_out = (MAX_HOLD != 0) && (hcnt == HMAX) && others;
    nxt_ptr   = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + IDXW'(1);
  end

  assign grant_vld = |grant;

  // Ownership FSM with registered grant, sink data and preempt pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hcnt      <= '0;
      grant     <= '0;
      grant_idx <= '0;
      a_sink    <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          a_sink <= 1'b0;
          if (win_vld) begin
            grant     <= N'(1) << win_idx;
            grant_idx <= win_idx;
            hcnt      <= HW'(1);
            state     <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (owner_rel || force_out) begin
            grant   <= '0;
            a_sink  <= 1'b0;
            ptr     <= nxt_ptr;
            preempt <= ~owner_rel;
            state   <= GAP;
          end else begin
            a_sink <= a_src[grant_idx];
            if (hcnt < HMAX) hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_foo_intf_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against an owner/pointer/hold-count model of the arbitration rules.
module tb_foo_intf_rr_arbiter;
  localparam int N    = 5;
  localparam int IDXW = 3;
  localparam int VW   = N + IDXW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0, rel = '0, a_src = '0;

  logic [N-1:0] g4, g2;
  logic v4, v2, as4, as2, p4, p2;
  logic [IDXW-1:0] i4, i2;

  int checks = 0;
  int errors = 0;
  bit inv_on = 1'b0;

  foo_intf_rr_arbiter #(.N(N), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .a_src(a_src),
    .grant(g4), .grant_vld(v4), .grant_idx(i4), .a_sink(as4), .preempt(p4));

  foo_intf_rr_arbiter #(.N(N), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .a_src(a_src),
    .grant(g2), .grant_vld(v2), .grant_idx(i2), .a_sink(as2), .preempt(p2));

  always #5 clk = ~clk;

  // Reference model: who owns the sink, for how long, and where the search starts.
  typedef struct {
    int owner;   // -1 when nobody owns the sink
    int held;    // granted cycles so far, including the current one
    int ptr;
    int last;
    bit pre;
    bit a;
  } mdl_t;

  mdl_t m4, m2;

  function automatic mdl_t mstep(mdl_t m, int mh, bit rn,
                                 logic [N-1:0] rq, logic [N-1:0] rl, logic [N-1:0] as);
    mdl_t r;
    r = m;
    r.pre = 1'b0;
    if (!rn) begin
      r.owner = -1; r.held = 0; r.ptr = 0; r.last = 0; r.a = 1'b0;
    end else if (m.owner >= 0) begin
      bit released, waiting, forced;
      released = rl[m.owner] || !rq[m.owner];
      waiting  = 1'b0;
      for (int j = 0; j < N; j++) if (j != m.owner && rq[j]) waiting = 1'b1;
      forced = (mh > 0) && (m.held >= mh) && waiting;
      if (released || forced) begin
        r.owner = -1;
        r.ptr   = (m.owner + 1) % N;
        r.pre   = !released;
        r.a     = 1'b0;
      end else begin
        r.held = m.held + 1;
        r.a    = as[m.owner];
      end
    end else begin
      r.a = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m.ptr + k) % N;
        if (r.owner < 0 && rq[c]) begin
          r.owner = c; r.last = c; r.held = 1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] expv(mdl_t m);
    logic [N-1:0] g;
    g = (m.owner >= 0) ? (N'(1) << m.owner) : '0;
    return {g, m.owner >= 0, IDXW'(m.last), m.a, m.pre};
  endfunction

  task automatic tick();
    @(posedge clk);
    m4 = mstep(m4, 4, rst_n, req, rel, a_src);
    m2 = mstep(m2, 2, rst_n, req, rel, a_src);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rel = '0; a_src = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // One-hot grant and grant_vld consistency, checked every cycle.
  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      if (!$onehot0(g4) || v4 !== |g4 || !$onehot0(g2) || v2 !== |g2) begin
        errors++;
        $display("FAIL invariant: g4=%b v4=%b g2=%b v2=%b", g4, v4, g2, v2);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req = '1; rel = '0; a_src = '1;
    tick(); tick();
    checks++;
    if ({g4, v4, i4, as4, p4} !== '0) begin
      errors++;
      $display("FAIL reset4: got %b, expected all zero", {g4, v4, i4, as4, p4});
    end
    checks++;
    if ({g2, v2, i2, as2, p2} !== '0) begin
      errors++;
      $display("FAIL reset2: got %b, expected all zero", {g2, v2, i2, as2, p2});
    end
    rst_n = 1'b1; req = '0; a_src = '0;
    inv_on = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00100;
    tick();
    checks++;
    if (g4 !== 5'b00100 || i4 !== 3'd2 || v4 !== 1'b1 || as4 !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%b idx=%0d vld=%b a=%b, expected 00100/2/1/0", g4, i4, v4, as4);
    end
    a_src = 5'b00100;
    tick();
    checks++;
    if (as4 !== 1'b1 || g4 !== 5'b00100) begin
      errors++;
      $display("FAIL single_a_sink: a_sink=%b grant=%b, expected 1/00100", as4, g4);
    end
    req = '0; a_src = '0;
    tick();
    checks++;
    if (g4 !== '0 || as4 !== 1'b0 || i4 !== 3'd2) begin
      errors++;
      $display("FAIL single_release: grant=%b a=%b idx=%0d, expected 0/0/2", g4, as4, i4);
    end
    tick();
  endtask

  task automatic test_fairness();
    int seq[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    req = '1;
    for (int e = 0; e < 6; e++) begin
      for (int c = 1; c <= 3; c++) begin
        tick();
        checks++;
        if (g4 !== (N'(1) << seq[e]) || p4 !== 1'b0) begin
          errors++;
          $display("FAIL rr_owner%0d_cyc%0d: grant=%b preempt=%b, expected %b/0", e, c, g4, p4, N'(1) << seq[e]);
        end
      end
      rel = N'(1) << seq[e];
      tick();
      rel = '0;
      checks++;
      if (g4 !== '0 || p4 !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: grant=%b preempt=%b, expected 0/0", e, g4, p4);
      end
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_preempt();
    do_reset();
    req = 5'b00010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) req = 5'b01010;
      checks++;
      if (g4 !== 5'b00010 || p4 !== 1'b0) begin
        errors++;
        $display("FAIL preempt_hold_cyc%0d: grant=%b preempt=%b, expected 00010/0", c, g4, p4);
      end
    end
    tick();
    checks++;
    if (g4 !== '0 || p4 !== 1'b1) begin
      errors++;
      $display("FAIL preempt_gap: grant=%b preempt=%b, expected 0/1", g4, p4);
    end
    tick();
    checks++;
    if (g4 !== 5'b01000 || i4 !== 3'd3 || p4 !== 1'b0) begin
      errors++;
      $display("FAIL preempt_new_owner: grant=%b idx=%0d preempt=%b, expected 01000/3/0", g4, i4, p4);
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 5'b10000;
    tick();
    checks++;
    if (g4 !== 5'b10000 || i4 !== 3'd4) begin
      errors++;
      $display("FAIL drop_owner: grant=%b idx=%0d, expected 10000/4", g4, i4);
    end
    req = 5'b00001;
    tick();
    checks++;
    if (g4 !== '0 || p4 !== 1'b0 || i4 !== 3'd4 || v4 !== 1'b0) begin
      errors++;
      $display("FAIL drop_gap: grant=%b preempt=%b idx=%0d vld=%b, expected 0/0/4/0", g4, p4, i4, v4);
    end
    tick();
    checks++;
    if (g4 !== 5'b00001 || i4 !== 3'd0) begin
      errors++;
      $display("FAIL drop_wrap: grant=%b idx=%0d, expected 00001/0", g4, i4);
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_sole_holder();
    do_reset();
    req = 5'b00001;
    for (int c = 0; c < 20; c++) begin
      a_src = N'($urandom);
      tick();
      checks++;
      if (g2 !== 5'b00001 || p2 !== 1'b0 || g4 !== 5'b00001 || p4 !== 1'b0) begin
        errors++;
        $display("FAIL sole_cyc%0d: g2=%b p2=%b g4=%b p4=%b, expected 00001/0", c, g2, p2, g4, p4);
      end
    end
    req = '0; a_src = '0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 5'b00100;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({g4, v4, i4, as4, p4} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got %b, expected all zero", {g4, v4, i4, as4, p4});
    end
    rst_n = 1'b1; req = '1;
    tick();
    checks++;
    if (g4 !== 5'b00001 || i4 !== 3'd0 || p4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_first: grant=%b idx=%0d preempt=%b, expected 00001/0/0", g4, i4, p4);
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [VW-1:0] e4, e2;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 4) == 0) req[b] = ~req[b];
      rel   = ($urandom_range(0, 3) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      a_src = N'($urandom);
      tick();
      e4 = expv(m4);
      e2 = expv(m2);
      checks++;
      if ({g4, v4, i4, as4, p4} !== e4) begin
        errors++;
        $display("FAIL random4_cyc%0d: got %b, expected %b", c, {g4, v4, i4, as4, p4}, e4);
      end
      checks++;
      if ({g2, v2, i2, as2, p2} !== e2) begin
        errors++;
        $display("FAIL random2_cyc%0d: got %b, expected %b", c, {g2, v2, i2, as2, p2}, e2);
      end
    end
    rst_n = 1'b1; req = '0; rel = '0;
    tick(); tick();
  endtask

  initial begin
    m4 = '{owner: -1, held: 0, ptr: 0, last: 0, pre: 1'b0, a: 1'b0};
    m2 = m4;
    test_reset();
    test_single();
    test_fairness();
    test_preempt();
    test_req_drop();
    test_sole_holder();
    test_reset_mid();
    test_random();
    inv_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
